// File: rtl/vga_logo_motion_ctrl.sv
// Per-frame DVD-bounce motion sequencer for the VGA logo: steps the logo
// position once per frame tick, reflects off the active-area edges and cycles the palette.
module vga_logo_motion_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned LOGO_W   = 128,
  parameter int unsigned LOGO_H   = 64,
  parameter int unsigned PAL_N    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       pause,
  input  logic [1:0] speed,
  input  logic       recenter,
  output logic [9:0] logo_x,
  output logic [9:0] logo_y,
  output logic [2:0] pal_idx,
  output logic       hit_x,
  output logic       hit_y,
  output logic       corner
);

  localparam logic [9:0] XMAX = 10'(H_ACTIVE - LOGO_W);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - LOGO_H);
  localparam logic [2:0] PAL_LAST = 3'(PAL_N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] state_q, state_d;
  logic       tick_d_q, tick_d_d;
  logic [9:0] logo_x_q, logo_x_d;
  logic [9:0] logo_y_q, logo_y_d;
  logic       dx_q, dx_d;  // 1 = moving right
  logic       dy_q, dy_d;  // 1 = moving down
  logic [2:0] pal_q, pal_d;
  logic       hit_x_q, hit_x_d;
  logic       hit_y_q, hit_y_d;
  logic       corner_q, corner_d;

  logic       tick_rise;
  logic [9:0] step;
  logic       hx, hy;

  always_comb begin
    tick_rise = frame_tick & ~tick_d_q;
    tick_d_d  = frame_tick;
    step      = {8'b0, speed} + 10'd1;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_IDLE; else if (pause) state_d = S_HOLD;
      S_HOLD:  if (!run) state_d = S_IDLE; else if (!pause) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    logo_x_d = logo_x_q;
    logo_y_d = logo_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    pal_d    = pal_q;
    hit_x_d  = 1'b0;
    hit_y_d  = 1'b0;
    corner_d = 1'b0;
    hx       = 1'b0;
    hy       = 1'b0;

    // Recenter has priority over a coincident tick; the tick is simply lost.
    if (recenter) begin
      logo_x_d = XMAX >> 1;
      logo_y_d = YMAX >> 1;
    end else if (state_q == S_RUN && tick_rise) begin
      if (dx_q) begin
        if ({1'b0, logo_x_q} + {1'b0, step} >= {1'b0, XMAX}) begin
          logo_x_d = XMAX;
          dx_d     = 1'b0;
          hx       = 1'b1;
        end else begin
          logo_x_d = logo_x_q + step;
        end
      end else begin
        if (logo_x_q <= step) begin
          logo_x_d = '0;
          dx_d     = 1'b1;
          hx       = 1'b1;
        end else begin
          logo_x_d = logo_x_q - step;
        end
      end

      if (dy_q) begin
        if ({1'b0, logo_y_q} + {1'b0, step} >= {1'b0, YMAX}) begin
          logo_y_d = YMAX;
          dy_d     = 1'b0;
          hy       = 1'b1;
        end else begin
          logo_y_d = logo_y_q + step;
        end
      end else begin
        if (logo_y_q <= step) begin
          logo_y_d = '0;
          dy_d     = 1'b1;
          hy       = 1'b1;
        end else begin
          logo_y_d = logo_y_q - step;
        end
      end

      hit_x_d  = hx;
      hit_y_d  = hy;
      corner_d = hx & hy;
      if (hx | hy) pal_d = (pal_q == PAL_LAST) ? '0 : pal_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tick_d_q <= 1'b0;
      logo_x_q <= '0;
      logo_y_q <= '0;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      pal_q    <= 3'd1;
      hit_x_q  <= 1'b0;
      hit_y_q  <= 1'b0;
      corner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_d_q <= tick_d_d;
      logo_x_q <= logo_x_d;
      logo_y_q <= logo_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      pal_q    <= pal_d;
      hit_x_q  <= hit_x_d;
      hit_y_q  <= hit_y_d;
      corner_q <= corner_d;
    end
  end

  assign logo_x  = logo_x_q;
  assign logo_y  = logo_y_q;
  assign pal_idx = pal_q;
  assign hit_x   = hit_x_q;
  assign hit_y   = hit_y_q;
  assign corner  = corner_q;

endmodule

// File: tb/tb_vga_logo_motion_ctrl.sv
// Directed bench for vga_logo_motion_ctrl; expected positions are hand-derived by
// unfolding each axis (walls every XMAX / YMAX pixels of travel).
module tb_vga_logo_motion_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       run;
  logic       pause;
  logic [1:0] speed;
  logic       recenter;
  logic [9:0] logo_x;
  logic [9:0] logo_y;
  logic [2:0] pal_idx;
  logic       hit_x;
  logic       hit_y;
  logic       corner;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vga_logo_motion_ctrl #(
    .H_ACTIVE(640),
    .V_ACTIVE(480),
    .LOGO_W  (128),
    .LOGO_H  (64),
    .PAL_N   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .run       (run),
    .pause     (pause),
    .speed     (speed),
    .recenter  (recenter),
    .logo_x    (logo_x),
    .logo_y    (logo_y),
    .pal_idx   (pal_idx),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .corner    (corner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int unsigned ex, input int unsigned ey,
                           input int unsigned ep);
    check({tag, ".x"}, logo_x, ex);
    check({tag, ".y"}, logo_y, ey);
    check({tag, ".pal"}, pal_idx, ep);
  endtask

  task automatic check_pulses(input string tag, input int unsigned ehx, input int unsigned ehy,
                              input int unsigned ec);
    check({tag, ".hit_x"}, hit_x, ehx);
    check({tag, ".hit_y"}, hit_y, ehy);
    check({tag, ".corner"}, corner, ec);
  endtask

  // Returns on the falling edge right after the update edge, while pulses are visible.
  task automatic tick_pulse();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick_pulse();
  endtask

  task automatic restart(input logic [1:0] spd);
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    speed = spd;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; pause = 1'b0;
    speed = 2'd0; recenter = 1'b0;
    repeat (3) @(negedge clk);
    check_pos("reset", 0, 0, 1);
    check_pulses("reset", 0, 0, 0);

    // Basic stepping at speed 0, then a long tick counting once
    rst_n = 1'b1; run = 1'b1;
    run_ticks(3);
    check_pos("step3", 3, 3, 1);
    check_pulses("step3", 0, 0, 0);
    @(negedge clk) frame_tick = 1'b1;
    repeat (10) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check_pos("held_tick", 4, 4, 1);

    // Right wall: 255 steps of 2 -> x=510; y bounced at 416 and came back to 322
    restart(2'd1);
    run_ticks(255);
    check_pos("pre_xhit", 510, 322, 2);
    speed = 2'd3;
    tick_pulse();
    check_pos("xhit", 512, 318, 3);
    check_pulses("xhit", 1, 0, 0);
    @(negedge clk);
    check("xhit_clear", hit_x, 0);
    tick_pulse();
    check_pos("after_xhit", 508, 314, 3);

    // Corner: with step 4 both walls coincide first at 6656 px of travel
    restart(2'd3);
    run_ticks(1663);
    check_pos("pre_corner", 508, 4, 4);
    tick_pulse();
    check_pos("corner", 512, 0, 5);
    check_pulses("corner", 1, 1, 1);
    @(negedge clk);
    check_pulses("corner_clear", 0, 0, 0);

    // Approach the left wall with varying speed
    run_ticks(126);
    check_pos("pre_left", 8, 328, 6);
    speed = 2'd2; tick_pulse();
    check("left_s3", logo_x, 5);
    speed = 2'd1; tick_pulse();
    check("left_5to3", logo_x, 3);
    check("left_5to3_hit", hit_x, 0);
    speed = 2'd0; tick_pulse();
    check("left_3to2", logo_x, 2);
    speed = 2'd1; tick_pulse();
    check_pos("left_hit", 0, 320, 7);
    check("left_hit_pulse", hit_x, 1);

    // Palette wraps 7 -> 0 on the next (top wall) hit
    speed = 2'd3;
    run_ticks(79);
    check_pos("pre_top", 316, 4, 7);
    tick_pulse();
    check_pos("pal_wrap", 320, 0, 0);
    check_pulses("pal_wrap", 0, 1, 0);

    // A tick coinciding with RUN->HOLD still applies; later ticks are ignored
    @(negedge clk) pause = 1'b1; frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check_pos("pause_edge", 324, 4, 0);
    run_ticks(4);
    check_pos("paused", 324, 4, 0);
    @(negedge clk) pause = 1'b0;
    tick_pulse();
    check_pos("resumed", 328, 8, 0);

    // Recenter beats a coincident tick
    @(negedge clk) recenter = 1'b1; frame_tick = 1'b1;
    @(negedge clk) recenter = 1'b0; frame_tick = 1'b0;
    check_pos("recenter", 256, 208, 0);
    check_pulses("recenter", 0, 0, 0);
    tick_pulse();
    check_pos("post_recenter", 260, 212, 0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_pos("async_rst", 0, 0, 1);
    @(negedge clk) rst_n = 1'b1; frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check_pos("tick_in_idle", 0, 0, 1);
    tick_pulse();
    check_pos("after_rst_run", 4, 4, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_logo_motion_ctrl.md
Name: vga_logo_motion_ctrl

Overview:
Per-frame motion sequencer for the VGA logo renderer. Once per video frame it advances the logo's top-left position (logo_x, logo_y) DVD-bounce style, reflects off the active-area edges and advances a palette index on every wall hit. It sits between the VGA timing generator, which supplies the frame tick, and the logo pixel datapath, which consumes position and colour. All updates land during vertical blanking, so the datapath never sees tearing.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
LOGO_W, 128, logo width in pixels
LOGO_H, 64, logo height in lines
PAL_N, 8, number of palette entries (power of 2)

Ports:
clk  in  1  system clock (pixel clock)
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  from timing generator; its rising edge marks frame start (vblank)
run  in  1  1 = motion enabled
pause  in  1  1 = hold position, ignore ticks
speed  in  2  step = speed+1 pixels per axis per frame (1..4)
recenter  in  1  single-cycle pulse: jump to centre position
logo_x  out  10  logo left column, 0..XMAX
logo_y  out  10  logo top line, 0..YMAX
pal_idx  out  3  current palette index
hit_x  out  1  one-cycle pulse on a left/right wall hit
hit_y  out  1  one-cycle pulse on a top/bottom wall hit
corner  out  1  one-cycle pulse when hit_x and hit_y occur in the same update

Behaviour:
- Constants: XMAX = H_ACTIVE-LOGO_W (512) and YMAX = V_ACTIVE-LOGO_H (416). All arithmetic is unsigned 10-bit with no wrap; bounds are checked before the write.
- Reset (async, rst_n=0): logo_x=0, logo_y=0, dx=+ (right), dy=+ (down), pal_idx=1, hit_x/hit_y/corner=0, FSM=IDLE, tick edge register=0.
- frame_tick is edge-detected internally: tick_rise = frame_tick & ~tick_d. A tick held high for N cycles counts once.
- FSM states:
  - IDLE: outputs hold. Go to RUN when run=1.
  - RUN: go to HOLD when pause=1. Go to IDLE when run=0.
  - HOLD: ticks are ignored. Go to RUN when pause=0. Go to IDLE when run=0.
- Update in RUN on tick_rise: position, direction, pal_idx and pulses register on the next clk edge (1-cycle latency). Pulses deassert on the following cycle.
- X axis, step s=speed+1:
  - dx=+: if logo_x+s >= XMAX then logo_x<=XMAX, dx<=-, hit_x=1; else logo_x+=s.
  - dx=-: if logo_x <= s then logo_x<=0, dx<=+, hit_x=1; else logo_x-=s.
  - Landing exactly on the bound counts as a hit.
- Y axis: same rule against YMAX with dy.
- Palette: on any hit (x, y or both), pal_idx<=pal_idx+1 mod PAL_N, exactly once per update. corner=hit_x&hit_y.
- recenter: valid in any state. On the next edge logo_x<=XMAX/2 (256), logo_y<=YMAX/2 (208). Directions, pal_idx and FSM state are unchanged. No pulses.
- recenter and tick_rise in the same cycle: recenter wins and the tick is dropped.
- Speed sampling: speed is sampled at tick_rise, so a change mid-frame applies to the next update only.
- State transition and tick in the same cycle: the transition is evaluated on the current state. A tick arriving on the same cycle as RUN→HOLD is still applied.
- Reset mid-operation: immediate return to the reset values. The first tick after release is applied only once the FSM has reached RUN.

Test Plan:
- Reset, run=1, speed=0, 3 rising ticks → logo_x=3, logo_y=3, pal_idx=1, no pulses. Tick held high 10 cycles → exactly one step.
- Force logo_x=510 moving right, speed=3, tick → logo_x=512, dx=-, hit_x pulse for exactly 1 cycle, pal_idx 1→2. Next tick → logo_x=508.
- logo_x=511, logo_y=415, both moving +, speed=0, tick → (512,416), hit_x=hit_y=corner=1, pal_idx +1 (not +2).
- Moving left at logo_x=2, speed=1, tick → logo_x=0 (hit). At logo_x=5 → 3 (no hit). pal_idx 7 wraps to 0 on a hit.
- pause=1, 4 ticks → position frozen. pause=0 plus tick → resumes stepping. recenter in the same cycle as a tick → (256,208), no step, no pulse.
- Assert rst_n=0 mid-run at (300,200) asynchronously between clock edges → outputs read 0/0/1 before the next clk edge. After release, ticks are ignored until run is seen high.
